// File: rtl/shift_load_reg_ctl.sv
// Parametrised shift/load/rotate register with step counter and end-of-track pulse.
// Define SHIFT_LOAD_REG_CTL_BOUNCE_EN to latch direction on LOAD and reflect at the track end.
module shift_load_reg_ctl #(
  parameter int               WIDTH   = 9,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             en,
  input  logic             dir,
  input  logic             s_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] Q,
  output logic             s_out,
  output logic [CNT_W-1:0] pos_cnt,
  output logic             end_hit,
  output logic             cur_dir
);

  localparam logic [1:0]       OP_SHIFT = 2'b01;
  localparam logic [1:0]       OP_LOAD  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             end_q, end_d;
  logic             eff_dir;
  logic             out_bit;
  logic             fill;
  logic             lead_new;

`ifdef SHIFT_LOAD_REG_CTL_BOUNCE_EN
  logic dir_q, dir_d;
  assign eff_dir = dir_q;
`else
  assign eff_dir = dir;
`endif

  assign out_bit = eff_dir ? q_q[0] : q_q[WIDTH-1];

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    end_d    = 1'b0;
    fill     = s_in;
    lead_new = 1'b0;
`ifdef SHIFT_LOAD_REG_CTL_BOUNCE_EN
    dir_d    = dir_q;
`endif
    if (op == OP_LOAD) begin
      q_d   = p_in;
      cnt_d = '0;
`ifdef SHIFT_LOAD_REG_CTL_BOUNCE_EN
      dir_d = dir;
`endif
    end else if (op[0] && en) begin
`ifdef SHIFT_LOAD_REG_CTL_BOUNCE_EN
      if (op == OP_SHIFT && out_bit) begin
        // Reflect: flip direction and step once the other way instead of losing the bit.
        dir_d = ~dir_q;
        q_d   = dir_q ? {q_q[WIDTH-2:0], s_in} : {s_in, q_q[WIDTH-1:1]};
        cnt_d = '0;
      end else
`endif
      begin
        fill     = op[1] ? out_bit : s_in;
        q_d      = eff_dir ? {fill, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill};
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        lead_new = eff_dir ? q_d[0] : q_d[WIDTH-1];
        end_d    = ~out_bit & lead_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RST_VAL;
      cnt_q <= '0;
      end_q <= 1'b0;
`ifdef SHIFT_LOAD_REG_CTL_BOUNCE_EN
      dir_q <= 1'b0;
`endif
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      end_q <= end_d;
`ifdef SHIFT_LOAD_REG_CTL_BOUNCE_EN
      dir_q <= dir_d;
`endif
    end
  end

  assign Q       = q_q;
  assign s_out   = out_bit;
  assign pos_cnt = cnt_q;
  assign end_hit = end_q;
  assign cur_dir = eff_dir;

endmodule

// File: tb/tb_shift_load_reg_ctl.sv
// Directed self-checking bench for shift_load_reg_ctl at WIDTH=9.
// Covers the bounce variant when SHIFT_LOAD_REG_CTL_BOUNCE_EN is defined.
module tb_shift_load_reg_ctl;

  localparam int W = 9;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic          s_in = 1'b0;
  logic [W-1:0]  p_in = '0;
  logic [W-1:0]  Q;
  logic          s_out;
  logic [CW-1:0] pos_cnt;
  logic          end_hit;
  logic          cur_dir;

  int n_cmp = 0;
  int n_err = 0;

  shift_load_reg_ctl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .en(en), .dir(dir), .s_in(s_in),
    .p_in(p_in), .Q(Q), .s_out(s_out), .pos_cnt(pos_cnt), .end_hit(end_hit),
    .cur_dir(cur_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic do_op(input logic [1:0] o, input logic e, input logic d,
                       input logic si, input logic [W-1:0] p);
    @(negedge clk);
    op = o; en = e; dir = d; s_in = si; p_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_q", Q, 9'h000);
    chk("rst_cnt", pos_cnt, 0);
    chk("rst_end", end_hit, 0);

`ifndef SHIFT_LOAD_REG_CTL_BOUNCE_EN
    // Build 0x0A5 with a nonzero count, then reset between edges.
    do_op(2'b10, 0, 0, 0, 9'h052);
    do_op(2'b01, 1, 0, 1, 9'h000);
    chk("pre_rst_q", Q, 9'h0A5);
    chk("pre_rst_cnt", pos_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_q", Q, 9'h000);
    chk("async_rst_cnt", pos_cnt, 0);
    chk("async_rst_end", end_hit, 0);
    @(negedge clk) rst_n = 1'b1;

    // Walk a single bit from LSB to MSB and beyond.
    do_op(2'b10, 0, 0, 0, 9'h001);
    for (int i = 1; i <= 8; i++) begin
      do_op(2'b01, 1, 0, 0, 9'h000);
      chk($sformatf("walk_end_%0d", i), end_hit, (i == 8));
    end
    chk("walk_q8", Q, 9'h100);
    chk("walk_cnt8", pos_cnt, 8);
    chk("walk_sout8", s_out, 1);
    do_op(2'b01, 1, 0, 0, 9'h000);
    chk("walk_q9", Q, 9'h000);
    chk("walk_cnt9", pos_cnt, 9);
    chk("walk_end9", end_hit, 0);
    do_op(2'b01, 1, 0, 0, 9'h000);
    chk("walk_cnt_sat", pos_cnt, 9);

    // Rotate wrap both ways, plus leading-end arrivals.
    do_op(2'b10, 0, 0, 0, 9'h001);
    do_op(2'b11, 1, 1, 0, 9'h000);
    chk("rot_r_wrap", Q, 9'h100);
    do_op(2'b11, 1, 0, 0, 9'h000);
    chk("rot_l_wrap", Q, 9'h001);
    chk("rot_cnt", pos_cnt, 2);
    do_op(2'b10, 0, 0, 0, 9'h002);
    do_op(2'b11, 1, 1, 0, 9'h000);
    chk("rot_r_q", Q, 9'h001);
    chk("rot_r_end", end_hit, 1);
    do_op(2'b10, 0, 0, 0, 9'h080);
    do_op(2'b11, 1, 0, 1, 9'h000);
    chk("rot_l_q", Q, 9'h100);
    chk("rot_l_end", end_hit, 1);
    chk("rot_l_cnt", pos_cnt, 1);

    // Disabled steps hold everything.
    for (int i = 0; i < 5; i++) do_op(2'b01, 0, 1, 1, 9'h000);
    chk("en0_q", Q, 9'h100);
    chk("en0_cnt", pos_cnt, 1);
    chk("en0_end", end_hit, 0);
    do_op(2'b10, 0, 0, 0, 9'h1FF);
    chk("load_en0_q", Q, 9'h1FF);
    chk("load_en0_cnt", pos_cnt, 0);

    // LOAD wins over a simultaneous step request.
    do_op(2'b10, 1, 1, 1, 9'h0F0);
    chk("load_pri_q", Q, 9'h0F0);
    chk("load_pri_cnt", pos_cnt, 0);
    do_op(2'b10, 0, 0, 0, 9'h000);
    do_op(2'b01, 1, 1, 1, 9'h000);
    chk("shr_fill_q", Q, 9'h100);
    chk("shr_fill_cnt", pos_cnt, 1);

    // s_out and cur_dir follow dir during HOLD.
    do_op(2'b00, 0, 1, 0, 9'h000);
    chk("hold_sout_r", s_out, 0);
    chk("hold_dir_r", cur_dir, 1);
    do_op(2'b00, 0, 0, 0, 9'h000);
    chk("hold_sout_l", s_out, 1);
    chk("hold_dir_l", cur_dir, 0);
    chk("hold_q", Q, 9'h100);
`else
    do_op(2'b10, 0, 0, 0, 9'h100);
    chk("bnc_sout", s_out, 1);
    do_op(2'b01, 1, 0, 0, 9'h000);
    chk("bnc_q", Q, 9'h080);
    chk("bnc_dir", cur_dir, 1);
    chk("bnc_cnt", pos_cnt, 0);
    chk("bnc_end", end_hit, 0);
    // dir input is ignored between LOADs.
    for (int i = 1; i <= 7; i++) begin
      do_op(2'b01, 1, 0, 0, 9'h000);
      chk($sformatf("bnc_end_%0d", i), end_hit, (i == 7));
    end
    chk("bnc_q7", Q, 9'h001);
    chk("bnc_cnt7", pos_cnt, 7);
    chk("bnc_dir7", cur_dir, 1);
    do_op(2'b11, 1, 0, 0, 9'h000);
    chk("bnc_rot_q", Q, 9'h100);
    chk("bnc_rot_dir", cur_dir, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
